// File: rtl/vio_4sub_seq.sv
// rtl/vio_4sub_seq.sv - bit-serial WIDTH-bit subtractor with start/busy/done handshake
//
// Computes {bout, diff} = {1'b0, a} - {1'b0, b} - bin one bit per clock, LSB
// first. Operands are captured on an accepted start (IDLE or DONE), processed
// over WIDTH SHIFT cycles, and the result is published on entry to DONE.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   start  operation request, honoured only in IDLE or DONE
//   a      minuend, captured on accepted start
//   b      subtrahend, captured on accepted start
//   bin    borrow-in, captured on accepted start
//   busy   high while bits are being processed (SHIFT)
//   done   single-cycle result-valid pulse (DONE)
//   diff   (a - b - bin) mod 2^WIDTH, held until the next result
//   bout   borrow-out, 1 iff a < b + bin

module vio_4sub_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] wr;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             last_bit;
  logic             d;
  logic             br_nxt;
  logic [WIDTH-1:0] wr_nxt;

  always_comb begin
    accept    = 1'b0;
    last_bit  = 1'b0;
    d         = 1'b0;
    br_nxt    = br;
    wr_nxt    = wr;
    state_nxt = state;

    // One full-subtractor slice on the current LSBs.
    d        = sa[0] ^ sb[0] ^ br;
    br_nxt   = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    wr_nxt   = {d, wr[WIDTH-1:1]};
    last_bit = (cnt == CW'(WIDTH - 1));

    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        // Back-to-back: a start seen while done is high is taken immediately.
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      sa    <= '0;
      sb    <= '0;
      wr    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      // Registered decodes of the next state keep busy/done glitch-free and
      // mutually exclusive.
      busy  <= (state_nxt == SHIFT);
      done  <= (state_nxt == DONE);

      if (accept) begin
        sa  <= a;
        sb  <= b;
        br  <= bin;
        cnt <= '0;
      end else if (state == SHIFT) begin
        sa  <= {1'b0, sa[WIDTH-1:1]};
        sb  <= {1'b0, sb[WIDTH-1:1]};
        br  <= br_nxt;
        wr  <= wr_nxt;
        cnt <= cnt + CW'(1);
      end

      // Publish the result only when the final bit has just been formed, so
      // diff/bout hold the previous result throughout a new operation.
      if (state == SHIFT && last_bit) begin
        diff <= wr_nxt;
        bout <= br_nxt;
      end
    end
  end

endmodule

// File: tb/tb_vio_4sub_seq.sv
// tb/tb_vio_4sub_seq.sv - scoreboard testbench for vio_4sub_seq

module tb_vio_4sub_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       bin;
  logic       busy;
  logic       done;
  logic [3:0] diff;
  logic       bout;

  int tests;
  int fails;
  logic [4:0] sb_q[$];

  vio_4sub_seq #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse pops one expected result.
  always @(negedge clk) begin
    logic [4:0] exp;
    if (done) begin
      check("busy_excl", 32'(busy), 32'd0);
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got diff=%0h bout=%0b expected no done", diff, bout);
      end else begin
        exp = sb_q.pop_front();
        check("result", 32'({bout, diff}), 32'(exp));
      end
    end
  end

  // Issue one operation; optionally check latency and busy length.
  task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_v, input logic tbin,
                        input logic [4:0] exp, input bit chk_timing);
    int n;
    int nbusy;
    @(negedge clk);
    a = ta; b = tb_v; bin = tbin; start = 1'b1;
    sb_q.push_back(exp);
    @(negedge clk);
    start = 1'b0;
    n = 1;
    nbusy = 0;
    while (!done && n < 20) begin
      if (busy) nbusy++;
      @(negedge clk);
      n++;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
    end else if (chk_timing) begin
      check("latency", 32'(n), 32'd5);
      check("busy_cycles", 32'(nbusy), 32'd4);
    end
  endtask

  initial begin
    int n;
    tests = 0;
    fails = 0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    rst = 1'b0;

    // Directed vectors with hand-computed {bout, diff}.
    run_op(4'd9,  4'd4,  1'b0, 5'h05, 1'b1);
    run_op(4'd3,  4'd5,  1'b0, 5'h1E, 1'b1);
    run_op(4'd0,  4'd0,  1'b1, 5'h1F, 1'b0);
    run_op(4'd15, 4'd15, 1'b1, 5'h1F, 1'b0);

    // Start pulsed while busy must be ignored.
    @(negedge clk);
    a = 4'd9; b = 4'd4; bin = 1'b0; start = 1'b1;
    sb_q.push_back(5'h05);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 4'd1; b = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = '0; b = '0;
    n = 3;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ign_latency", 32'(n), 32'd5);
    repeat (8) @(negedge clk);
    check("ign_queue_empty", 32'(sb_q.size()), 32'd0);

    // Back-to-back with start held high.
    @(negedge clk);
    a = 4'd7; b = 4'd2; bin = 1'b0; start = 1'b1;
    sb_q.push_back(5'h05);
    @(negedge clk);
    a = 4'd2; b = 4'd7;
    sb_q.push_back(5'h1B);
    repeat (4) @(negedge clk);
    check("b2b_done1", 32'(done), 32'd1);
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy2", 32'(busy), 32'd1);
    @(negedge clk);
    check("b2b_hold_diff", 32'(diff), 32'd5);
    check("b2b_hold_bout", 32'(bout), 32'd0);
    repeat (3) @(negedge clk);
    check("b2b_done2", 32'(done), 32'd1);

    // Reset during the 2nd SHIFT cycle abandons the operation.
    repeat (2) @(negedge clk);
    a = 4'd6; b = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_diff", 32'(diff), 32'd0);
    check("mid_rst_bout", 32'(bout), 32'd0);
    repeat (6) @(negedge clk);
    run_op(4'd6, 4'd1, 1'b0, 5'h05, 1'b1);

    // Exhaustive sweep against the reference expression.
    for (int i = 0; i < 512; i++) begin
      logic [3:0] xa;
      logic [3:0] xb;
      logic       xc;
      logic [4:0] ref_v;
      xa = 4'(i >> 5);
      xb = 4'(i >> 1);
      xc = i[0];
      ref_v = {1'b0, xa} - {1'b0, xb} - {4'd0, xc};
      run_op(xa, xb, xc, ref_v, 1'b0);
    end

    repeat (10) @(negedge clk);
    check("final_queue_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
